alu8_pipe: RTL and testbench
============================

ALU8_PIPE -- requirements
Module: alu8_pipe

Interface
REQ-001 Parameter: DATA_W, 8, operand/result width; only 8 is supported and verified.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block accepts a request this cycle.
REQ-006 Port: op  input  4  opcode, per REQ-012.
REQ-007 Port: a  input  8  operand A.
REQ-008 Port: b  input  8  operand B.
REQ-009 Port: out_valid  output  1  result registers hold an unconsumed result.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: result  output  8  result low byte. Port: result_hi  output  8  MUL high byte, else 0. Port: flags  output  5  {err,V,N,Z,C}.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a by 1 (logical), 8 ROL a, 9 ROR a, 10 INC a, 11 DEC a, 12 MUL (unsigned 8x8->16), 13 CMP (flags of a-b, result=a), 14-15 reserved.
REQ-013 Accept (handshake) occurs when in_valid && in_ready; operands and op are captured on that edge; a, b and op are don't-care otherwise.
REQ-014 States: IDLE (no result held), MUL (iterating), HOLD (out_valid=1).
REQ-015 in_ready = (state==IDLE) || (state==HOLD && out_ready); in_ready=0 in MUL.
REQ-016 Non-MUL ops: result, result_hi and flags registered on the accept edge; out_valid=1 the next cycle (latency 1); back-to-back throughput 1 per cycle while out_ready=1.
REQ-017 MUL: shift-add over 8 iterations, one per cycle; out_valid asserts exactly 8 cycles after the accept edge; result={product[7:0]}, result_hi=product[15:8].
REQ-018 Result consumed when out_valid && out_ready; if no accept on the same edge, go IDLE and out_valid=0; if an accept occurs on the same edge, load the new op (HOLD or MUL).
REQ-019 While out_valid=1 and out_ready=0, result, result_hi and flags are held stable.
REQ-020 C: ADD/INC carry-out; SUB/CMP/DEC 1 when no borrow (a>=b, a!=0 for DEC); SHL/ROL bit shifted out of bit 7; SHR/ROR bit shifted out of bit 0; MUL 1 when result_hi!=0; logic ops 0.
REQ-021 Z: result==0 (CMP: a-b==0; MUL: full 16-bit product==0). N: result[7] (CMP: (a-b)[7]; MUL: result_hi[7]).
REQ-022 V: two's-complement overflow for ADD, SUB, CMP, INC (0x7F->0x80), DEC (0x80->0x7F); 0 for all other ops.
REQ-023 Reserved op: result=0, result_hi=0, err=1, C=V=N=0, Z=1; latency 1; err=0 for all valid ops.
REQ-024 All arithmetic modulo 2^8 except MUL (16-bit exact).

Reset
REQ-025 When rst=1 on a clock edge: state=IDLE, out_valid=0, result=0, result_hi=0, flags=0, MUL iteration counter=0; in_ready=1 from the first cycle after rst deasserts.
REQ-026 rst has priority over any simultaneous accept or consume; a MUL in progress is abandoned and never produces out_valid.
REQ-027 in_ready is 0 while rst=1.

Verification
REQ-028 ADD a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, result=0x00, C=1 Z=1 N=0 V=0.
REQ-029 SUB a=0x80 b=0x01 -> result=0x7F, V=1 N=0 Z=0 C=1; CMP a=0x05 b=0x05 -> result=0x05, Z=1 C=1.
REQ-030 MUL a=0x0F b=0x11 -> in_ready=0 for 8 cycles, out_valid=1 on cycle 8, result=0xFF, result_hi=0x00, C=0; MUL 0xFF*0xFF -> 0xFE01, C=1 N=1.
REQ-031 Back-to-back ADD, XOR, INC with out_ready held 0 for 3 cycles after first result -> first result stable 3 cycles, in_ready=0, then three results in order, one per cycle.
REQ-032 rst pulsed 1 cycle at MUL iteration 4 -> out_valid stays 0, all outputs 0, next ADD 0x01+0x02 returns 0x03 after 1 cycle.
REQ-033 op=14 with any operands -> result=0x00, flags err=1 Z=1, others 0.

Source files
------------

// File: rtl/alu8_pipe.sv
// Handshaked 8-bit ALU: single-cycle ops register on accept, MUL runs an
// 8-step shift-add sequence before presenting its 16-bit product.
module alu8_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic [4:0]        flags
);
    localparam int W = DATA_W;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_CMP = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

    state_e         state, state_nxt;
    logic           accept, consume, mul_last;
    logic [W-1:0]   diff, alu_res, flag_src;
    logic [W:0]     sum;
    logic           c_bit, v_bit, err_bit;
    logic [4:0]     alu_flags;
    logic [2*W-1:0] mcand, acc, acc_nxt;
    logic [W-1:0]   mplr;
    logic [2:0]     cnt;

    assign out_valid = (state == S_HOLD);
    assign in_ready  = !rst && ((state == S_IDLE) || (state == S_HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign mul_last  = (state == S_MUL) && (cnt == 3'd7);
    assign diff      = a - b;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        c_bit   = 1'b0;
        v_bit   = 1'b0;
        err_bit = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[W-1:0];
                c_bit   = sum[W];
                v_bit   = (a[W-1] == b[W-1]) && (alu_res[W-1] != a[W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = (op == OP_CMP) ? a : diff;
                c_bit   = (a >= b);
                v_bit   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin alu_res = {a[W-2:0], 1'b0};   c_bit = a[W-1]; end
            OP_SHR: begin alu_res = {1'b0, a[W-1:1]};   c_bit = a[0];   end
            OP_ROL: begin alu_res = {a[W-2:0], a[W-1]}; c_bit = a[W-1]; end
            OP_ROR: begin alu_res = {a[0], a[W-1:1]};   c_bit = a[0];   end
            OP_INC: begin
                sum     = {1'b0, a} + {{W{1'b0}}, 1'b1};
                alu_res = sum[W-1:0];
                c_bit   = sum[W];
                v_bit   = !a[W-1] && alu_res[W-1];
            end
            OP_DEC: begin
                alu_res = a - {{(W-1){1'b0}}, 1'b1};
                c_bit   = |a;
                v_bit   = a[W-1] && !alu_res[W-1];
            end
            OP_MUL:  ;
            default: err_bit = 1'b1;
        endcase
        // CMP reports flags of the difference while passing a through.
        flag_src  = (op == OP_CMP) ? diff : alu_res;
        alu_flags = {err_bit, v_bit, flag_src[W-1], (flag_src == '0), c_bit};
    end

    assign acc_nxt = mplr[0] ? (acc + mcand) : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (op == OP_MUL) ? S_MUL : S_HOLD;
            S_MUL:  if (mul_last) state_nxt = S_HOLD;
            S_HOLD: begin
                if (accept)       state_nxt = (op == OP_MUL) ? S_MUL : S_HOLD;
                else if (consume) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                mcand <= {{W{1'b0}}, a};
                mplr  <= b;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                result    <= alu_res;
                result_hi <= '0;
                flags     <= alu_flags;
            end
        end else if (state == S_MUL) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 3'd1;
            if (mul_last) begin
                result    <= acc_nxt[W-1:0];
                result_hi <= acc_nxt[2*W-1:W];
                flags     <= {1'b0, 1'b0, acc_nxt[2*W-1], (acc_nxt == '0), |acc_nxt[2*W-1:W]};
            end
        end
    end
endmodule

// File: tb/tb_alu8_pipe.sv
// Self-checking bench for alu8_pipe: a reference model feeds a scoreboard
// queue on every accept; a monitor pops and compares on every consume.
module tb_alu8_pipe;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] op;
    logic [7:0] a, b, result, result_hi;
    logic [4:0] flags;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] fl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu8_pipe #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t        e;
        logic [8:0]  w;
        logic [7:0]  r, d;
        logic [15:0] p;
        int          sx, sy, s;
        logic        c, v;
        sx = int'($signed(x));
        sy = int'($signed(y));
        w = '0; r = '0; c = 1'b0; v = 1'b0; p = '0; s = 0;
        d = x - y;
        e = '0;
        case (o)
            4'd0:  begin w = {1'b0, x} + {1'b0, y}; r = w[7:0]; c = w[8];
                         s = sx + sy; v = (s > 127) || (s < -128); end
            4'd1:  begin r = d; c = (x >= y); s = sx - sy; v = (s > 127) || (s < -128); end
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ~x;
            4'd6:  begin r = {x[6:0], 1'b0}; c = x[7]; end
            4'd7:  begin r = {1'b0, x[7:1]}; c = x[0]; end
            4'd8:  begin r = {x[6:0], x[7]}; c = x[7]; end
            4'd9:  begin r = {x[0], x[7:1]}; c = x[0]; end
            4'd10: begin w = {1'b0, x} + 9'd1; r = w[7:0]; c = w[8]; v = (sx + 1) > 127; end
            4'd11: begin r = x - 8'd1; c = (x != 8'd0); v = (sx - 1) < -128; end
            4'd12: begin
                p = 16'(x) * 16'(y);
                e.res = p[7:0];
                e.hi  = p[15:8];
                e.fl  = {1'b0, 1'b0, p[15], (p == 16'd0), (p[15:8] != 8'd0)};
                return e;
            end
            4'd13: begin
                s = sx - sy;
                e.res = x;
                e.fl  = {1'b0, (s > 127) || (s < -128), d[7], (d == 8'd0), (x >= y)};
                return e;
            end
            default: begin
                e.fl = 5'b10010;
                return e;
            end
        endcase
        e.res = r;
        e.fl  = {1'b0, v, r[7], (r == 8'd0), c};
        return e;
    endfunction

    // Caller is at a negedge; returns at the negedge after the accept edge
    // with in_valid still high so a following send keeps 1 op/cycle.
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        bit ok = 1'b0;
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 64 && !ok; i++) begin
            #1;
            if (in_ready) begin
                sb.push_back(model(o, x, y));
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",    32'(result),    32'(e.res));
                check("result_hi", 32'(result_hi), 32'(e.hi));
                check("flags",     32'(flags),     32'(e.fl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_result_hi", 32'(result_hi), 32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // ADD wrap with latency-1 check, then SUB overflow and CMP equal
        send(4'd0, 8'hFF, 8'h01);
        in_valid = 1'b0;
        #1 check("add_latency", 32'(out_valid), 32'd1);
        check("add_flags_direct", 32'(flags), 32'h03);
        @(negedge clk);
        send(4'd1, 8'h80, 8'h01);
        send(4'd13, 8'h05, 8'h05);
        in_valid = 1'b0;
        @(negedge clk);

        // MUL: in_ready low for 8 cycles, result on the 8th
        send(4'd12, 8'h0F, 8'h11);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("mul_in_ready_low", 32'(in_ready),  32'd0);
            check("mul_no_valid",     32'(out_valid), 32'd0);
            @(negedge clk);
        end
        #1 check("mul_valid_cycle8", 32'(out_valid), 32'd1);
        check("mul_result_direct", 32'(result), 32'hFF);
        @(negedge clk);
        send(4'd12, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        @(negedge clk);

        // Every opcode with random operands, back to back
        for (int k = 0; k < 16; k++)
            send(4'(k), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        // Boundary operands
        send(4'd10, 8'h7F, 8'h00);
        send(4'd10, 8'hFF, 8'h00);
        send(4'd11, 8'h80, 8'h00);
        send(4'd11, 8'h00, 8'h00);
        send(4'd6,  8'h80, 8'h00);
        send(4'd7,  8'h01, 8'h00);
        send(4'd9,  8'h01, 8'h00);
        send(4'd1,  8'h00, 8'h01);
        send(4'd14, 8'hA5, 8'h5A);
        send(4'd15, 8'h00, 8'h00);
        send(4'd12, 8'h00, 8'h37);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Back-pressure: first result held stable three cycles
        send(4'd0, 8'h12, 8'h34);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd4; a = 8'h0F; b = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_valid",    32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready),  32'd0);
            check("hold_result",   32'(result),    32'h46);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(4'd4, 8'h0F, 8'hF0);
        send(4'd10, 8'h41, 8'h00);
        in_valid = 1'b0;
        #1 check("b2b_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1 check("b2b_drained", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Reset mid-MUL abandons the product
        send(4'd12, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1 check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abandon_result",    32'(result),    32'd0);
        check("abandon_result_hi", 32'(result_hi), 32'd0);
        check("abandon_flags",     32'(flags),     32'd0);
        for (int i = 0; i < 10; i++) begin
            check("abandon_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        send(4'd0, 8'h01, 8'h02);
        in_valid = 1'b0;
        #1 check("post_rst_add_valid", 32'(out_valid), 32'd1);
        check("post_rst_add_result", 32'(result), 32'h03);

        repeat (12) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
